// File: rtl/uart_mmio_bridge.sv
`default_nettype none
// +----------------------------------------------------------------+
// | uart_mmio_bridge: UART command frames -> single MMIO accesses. |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module uart_mmio_bridge #(
  parameter int ADDR_WIDTH     = 11,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_WIDTH       = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_empty,
  output logic                  rd_uart,
  output logic [7:0]            tx_data,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic                  bus_cs,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wr_data,
  input  logic [31:0]           bus_rd_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WDATA  = 3'd2,
    S_BUS_WR = 3'd3,
    S_BUS_RD = 3'd4,
    S_RESP   = 3'd5,
    S_ACK    = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [7:0]          c_cmd_wr  = 8'h57;
  localparam logic [7:0]          c_cmd_rd  = 8'h52;
  localparam logic [7:0]          c_ack     = 8'h4B;
  localparam logic [7:0]          c_err     = 8'h3F;
  localparam logic [TO_WIDTH-1:0] c_to_last = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_is_write;
  logic [1:0]            r_cnt;
  logic [TO_WIDTH-1:0]   r_to;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_push    = 1'b0;
    w_last    = 1'b0;
    tx_data   = 8'h00;
    bus_cs    = 1'b0;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rx_empty) begin
          w_pop  = 1'b1;
          w_next = (rx_data == c_cmd_wr || rx_data == c_cmd_rd) ? S_ADDR : S_ERR;
        end
      end
      S_ADDR: begin
        w_last = (r_cnt == 2'd1);
        if (!rx_empty) begin
          w_pop = 1'b1;
          if (w_last) w_next = r_is_write ? S_WDATA : S_BUS_RD;
        end else if (r_to == c_to_last) begin
          w_next = S_ERR;
        end
      end
      S_WDATA: begin
        w_last = (r_cnt == 2'd3);
        if (!rx_empty) begin
          w_pop = 1'b1;
          if (w_last) w_next = S_BUS_WR;
        end else if (r_to == c_to_last) begin
          w_next = S_ERR;
        end
      end
      S_BUS_WR: begin
        bus_cs    = 1'b1;
        bus_write = 1'b1;
        w_next    = S_ACK;
      end
      S_BUS_RD: begin
        bus_cs   = 1'b1;
        bus_read = 1'b1;
        w_next   = S_RESP;
      end
      S_RESP: begin
        tx_data = r_rdata[31:24];
        if (!tx_full) begin
          w_push = 1'b1;
          if (r_cnt == 2'd3) w_next = S_IDLE;
        end
      end
      S_ACK: begin
        tx_data = c_ack;
        if (!tx_full) begin
          w_push = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_ERR: begin
        tx_data = c_err;
        if (!tx_full) begin
          w_push = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The pop strobe is gated by reset so a non-empty FIFO is never popped while held in reset.
  assign rd_uart     = w_pop & reset_n;
  assign wr_uart     = w_push;
  assign busy        = (r_state != S_IDLE);
  assign bus_addr    = r_addr;
  assign bus_wr_data = r_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_write <= 1'b0;
      r_cnt      <= 2'd0;
      r_to       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 2'd0;
          r_to  <= '0;
          if (w_pop) r_is_write <= (rx_data == c_cmd_wr);
        end
        S_ADDR, S_WDATA: begin
          if (w_pop) begin
            r_to  <= '0;
            r_cnt <= w_last ? 2'd0 : r_cnt + 2'd1;
            // Only the low ADDR_WIDTH bits of the 16-bit frame address survive the shift.
            if (r_state == S_ADDR) r_addr  <= ADDR_WIDTH'({r_addr, rx_data});
            else                   r_wdata <= {r_wdata[23:0], rx_data};
          end else if (r_to == c_to_last) begin
            r_to  <= '0;
            r_cnt <= 2'd0;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_BUS_RD: begin
          r_rdata <= bus_rd_data;
          r_cnt   <= 2'd0;
          r_to    <= '0;
        end
        S_RESP: begin
          r_to <= '0;
          if (w_push) begin
            r_rdata <= {r_rdata[23:0], 8'h00};
            r_cnt   <= r_cnt + 2'd1;
          end
        end
        default: begin
          r_cnt <= 2'd0;
          r_to  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
